// File: rtl/onchip_ram_avmm.sv
// Single-port on-chip RAM behind an Avalon-MM slave.
// Width and depth are configurable, writes take a per-byte mask, and reads return after a
// fixed latency of 1 or 2 enabled cycles together with readdatavalid. A clear engine fills
// every word with FILL_VALUE after reset (optional) or on clear_req. While it runs it holds
// waitrequest, so the fill always sees a quiet bus. clken low freezes every register.
module onchip_ram_avmm #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       DEPTH          = 1024,
  parameter int unsigned       ADDR_W         = $clog2(DEPTH),
  parameter int unsigned       READ_LATENCY   = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE     = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  clken,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int unsigned       NumBytes = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  // Elaboration-time guard on the parameter combinations the datapath relies on.
  if ((DATA_W % 8) != 0 || DATA_W == 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      (1 << ADDR_W) != DEPTH || (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_bad_param
    $error("onchip_ram_avmm: unsupported parameter combination");
  end

  typedef enum logic {
    StClear,
    StRun
  } state_e;

  localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StRun;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [ADDR_W-1:0]   w_clr_cnt_next;
  logic                r_clear_done;
  logic                w_clear_done_next;
  logic                w_fill_we;

  logic                w_cmd_acc;
  logic                w_wr_acc;
  logic                w_rd_acc;

  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [NumBytes-1:0] w_mem_be;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_vld;

  // ---------------------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------------------

  // FSM state, clear address counter and sticky done flag; all frozen while clken is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ResetState;
      r_clr_cnt    <= '0;
      r_clear_done <= 1'b0;
    end else if (clken) begin
      r_state      <= w_state_next;
      r_clr_cnt    <= w_clr_cnt_next;
      r_clear_done <= w_clear_done_next;
    end
  end

  // Next-state logic: CLEAR walks 0..DEPTH-1 once; RUN waits for clear_req.
  always_comb begin
    w_state_next      = r_state;
    w_clr_cnt_next    = r_clr_cnt;
    w_clear_done_next = r_clear_done;
    w_fill_we         = 1'b0;
    unique case (r_state)
      StClear: begin
        w_fill_we = 1'b1;
        if (r_clr_cnt == LastAddr) begin
          w_state_next      = StRun;
          w_clr_cnt_next    = '0;
          w_clear_done_next = 1'b1;
        end else begin
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end
      end
      StRun: begin
        if (clear_req) begin
          w_state_next      = StClear;
          w_clr_cnt_next    = '0;
          w_clear_done_next = 1'b0;
        end
      end
      default: begin
        w_state_next = ResetState;
      end
    endcase
  end

  assign waitrequest = (r_state == StClear);
  assign clear_busy  = (r_state == StClear);
  assign clear_done  = r_clear_done;

  // ---------------------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------------------

  // Commands presented under waitrequest are simply dropped; write wins over a simultaneous
  // read, so a same-cycle read/write collision cannot occur.
  assign w_cmd_acc = chipselect & (read | write) & ~waitrequest & clken;
  assign w_wr_acc  = w_cmd_acc & write;
  assign w_rd_acc  = w_cmd_acc & read & ~write;

  // Single write port shared by the clear engine and the slave; the fill owns it in CLEAR.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = address;
    w_mem_wdata = writedata;
    w_mem_be    = byteenable;
    if (w_fill_we && clken) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_clr_cnt;
      w_mem_wdata = FILL_VALUE;
      w_mem_be    = '1;
    end else if (w_wr_acc) begin
      w_mem_we = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------------------

  // Byte-masked array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (w_mem_be[i]) begin
          r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------------------

  // First stage: registered array read. Data only moves on an accepted read so that the
  // visible readdata holds between results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else if (clken) begin
      r_rd_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[address];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_vld;

    // Second stage: extra output register, again only loaded when a result passes through.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_out_data <= '0;
        r_out_vld  <= 1'b0;
      end else if (clken) begin
        r_out_vld <= r_rd_vld;
        if (r_rd_vld) begin
          r_out_data <= r_rd_data;
        end
      end
    end

    assign readdata      = r_out_data;
    assign readdatavalid = r_out_vld;
  end else begin : g_lat1
    assign readdata      = r_rd_data;
    assign readdatavalid = r_rd_vld;
  end

  // ---------------------------------------------------------------------------------------
  // Internal consistency properties
  // ---------------------------------------------------------------------------------------

  // The clear counter is parked at zero whenever the engine is idle.
  a_cnt_idle_zero : assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == StRun) |-> (r_clr_cnt == '0));

  // No slave write is ever accepted while the fill owns the array.
  a_no_wr_in_clear : assert property (@(posedge clk) disable iff (!reset_n)
    (r_state == StClear) |-> !w_wr_acc);

endmodule

// File: tb/tb_onchip_ram_avmm.sv
// Scoreboard bench for onchip_ram_avmm. Two instances are exercised side by side:
//   dut0: defaults (1024 x 32, latency 1, fill 0, clear on reset)
//   dut1: 16 x 32, latency 2, fill 0xA5A5A5A5, no clear on reset
// Stimulus pushes expected read results (data plus due enabled-cycle) into a queue; a
// negedge monitor pops and compares whenever a result is due.
module tb_onchip_ram_avmm;

  localparam int NDut = 2;

  logic        clk;
  logic        rst_n   [NDut];
  logic [9:0]  addr    [NDut];
  logic        cs      [NDut];
  logic        rd      [NDut];
  logic        wr      [NDut];
  logic [31:0] wdata   [NDut];
  logic [3:0]  be      [NDut];
  logic        clken   [NDut];
  logic        creq    [NDut];
  logic [31:0] rdata   [NDut];
  logic        rdv     [NDut];
  logic        wreq    [NDut];
  logic        cbusy   [NDut];
  logic        cdone   [NDut];

  onchip_ram_avmm u_dut0 (
    .clk          (clk),
    .reset_n      (rst_n[0]),
    .address      (addr[0]),
    .chipselect   (cs[0]),
    .read         (rd[0]),
    .write        (wr[0]),
    .writedata    (wdata[0]),
    .byteenable   (be[0]),
    .clken        (clken[0]),
    .readdata     (rdata[0]),
    .readdatavalid(rdv[0]),
    .waitrequest  (wreq[0]),
    .clear_req    (creq[0]),
    .clear_busy   (cbusy[0]),
    .clear_done   (cdone[0])
  );

  onchip_ram_avmm #(
    .DATA_W        (32),
    .DEPTH         (16),
    .ADDR_W        (4),
    .READ_LATENCY  (2),
    .FILL_VALUE    (32'hA5A5_A5A5),
    .CLEAR_ON_RESET(1'b0)
  ) u_dut1 (
    .clk          (clk),
    .reset_n      (rst_n[1]),
    .address      (addr[1][3:0]),
    .chipselect   (cs[1]),
    .read         (rd[1]),
    .write        (wr[1]),
    .writedata    (wdata[1]),
    .byteenable   (be[1]),
    .clken        (clken[1]),
    .readdata     (rdata[1]),
    .readdatavalid(rdv[1]),
    .waitrequest  (wreq[1]),
    .clear_req    (creq[1]),
    .clear_busy   (cbusy[1]),
    .clear_done   (cdone[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------------------
  typedef struct {
    int          dut;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem  [NDut][1024];
  bit          run_mode [NDut];
  int          ecnt     [NDut];
  int          last_cnt [NDut];
  logic [31:0] last_data[NDut];
  logic        last_rdv [NDut];
  int          n_chk;
  int          n_fail;

  function automatic int depth_of(input int k);
    return (k == 0) ? 1024 : 16;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] fill_of(input int k);
    return (k == 0) ? 32'h0 : 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input int k, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %h, expected %h (t=%0t)", k, nm, act, exp, $time);
    end
  endtask

  task automatic model_write(input int k, input int a, input logic [31:0] d,
                             input logic [3:0] b);
    for (int i = 0; i < 4; i++) begin
      if (b[i]) ref_mem[k][a][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < depth_of(k); i++) ref_mem[k][i] = fill_of(k);
  endtask

  // Enabled-cycle counter per instance: the time base for read latency.
  always @(posedge clk) begin
    for (int k = 0; k < NDut; k++) begin
      if (rst_n[k] && clken[k]) ecnt[k] <= ecnt[k] + 1;
    end
  end

  // Monitor: on each enabled cycle either the head result is due and must appear, or
  // readdatavalid must be low with readdata held; on frozen cycles everything must hold.
  always @(negedge clk) begin
    int idx;
    for (int k = 0; k < NDut; k++) begin
      if (!rst_n[k]) begin
        for (int j = sb.size() - 1; j >= 0; j--) begin
          if (sb[j].dut == k) sb.delete(j);
        end
        last_cnt[k]  = ecnt[k];
        last_data[k] = '0;
        last_rdv[k]  = 1'b0;
      end else if (ecnt[k] != last_cnt[k]) begin
        idx = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (idx < 0 && sb[j].dut == k) idx = j;
        end
        if (idx >= 0 && sb[idx].due == ecnt[k]) begin
          chk(k, "readdatavalid when due", 32'(rdv[k]), 32'd1);
          chk(k, "readdata", rdata[k], sb[idx].data);
          last_data[k] = sb[idx].data;
          sb.delete(idx);
        end else begin
          chk(k, "readdatavalid idle", 32'(rdv[k]), 32'd0);
          chk(k, "readdata held", rdata[k], last_data[k]);
          if (idx >= 0 && sb[idx].due < ecnt[k]) begin
            n_chk++;
            n_fail++;
            $display("FAIL dut%0d missed read result: due %0d, now %0d", k, sb[idx].due,
                     ecnt[k]);
            sb.delete(idx);
          end
        end
        last_rdv[k] = rdv[k];
        last_cnt[k] = ecnt[k];
      end else begin
        chk(k, "frozen readdatavalid", 32'(rdv[k]), 32'(last_rdv[k]));
        chk(k, "frozen readdata", rdata[k], last_data[k]);
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of bus inputs and predict its effect from the acceptance rule.
  task automatic drive(input int k, input bit c_s, input bit r, input bit w, input int a,
                       input logic [31:0] d, input logic [3:0] b, input bit ce);
    bit   acc;
    exp_t e;
    cs[k]    = c_s;
    rd[k]    = r;
    wr[k]    = w;
    addr[k]  = 10'(a);
    wdata[k] = d;
    be[k]    = b;
    clken[k] = ce;
    acc = c_s && (r || w) && ce && run_mode[k];
    if (acc && w) begin
      model_write(k, a, d, b);
    end else if (acc) begin
      e.dut  = k;
      e.data = ref_mem[k][a];
      e.due  = ecnt[k] + lat_of(k);
      sb.push_back(e);
    end
  endtask

  task automatic cyc(input int k, input bit c_s, input bit r, input bit w, input int a,
                     input logic [31:0] d, input logic [3:0] b, input bit ce);
    drive(k, c_s, r, w, a, d, b, ce);
    tick();
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) cyc(k, 0, 0, 0, 0, 32'h0, 4'h0, 1);
  endtask

  task automatic rd1(input int k, input int a);
    cyc(k, 1, 1, 0, a, 32'h0, 4'h0, 1);
  endtask

  task automatic wr1(input int k, input int a, input logic [31:0] d, input logic [3:0] b);
    cyc(k, 1, 0, 1, a, d, b, 1);
  endtask

  task automatic random_drive(input int k);
    int op;
    op = $urandom_range(0, 9);
    drive(k, $urandom_range(0, 7) != 0, (op < 4) || (op == 9), (op >= 4 && op < 8) || (op == 9),
          $urandom_range(0, depth_of(k) - 1), $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 9) != 0);
  endtask

  // Run a clear to completion and check its length. With extras, a write is attempted
  // mid-clear, clken is dropped for 3 cycles and a second clear_req is issued.
  task automatic run_clear(input int k, input bit from_req, input bit extras);
    int n;
    run_mode[k] = 1'b0;
    if (from_req) begin
      creq[k] = 1'b1;
      idle(k, 1);
      creq[k] = 1'b0;
      chk(k, "clear_done dropped by clear_req", 32'(cdone[k]), 32'd0);
    end
    chk(k, "waitrequest at clear start", 32'(wreq[k]), 32'd1);
    chk(k, "clear_busy at clear start", 32'(cbusy[k]), 32'd1);
    n = 0;
    while (wreq[k] && n < 5000) begin
      if (extras && n == 4) begin
        cyc(k, 1, 0, 1, 3, 32'h1234_5678, 4'hF, 1);
      end else if (extras && n >= 6 && n < 9) begin
        cyc(k, 0, 0, 0, 0, 32'h0, 4'h0, 0);
      end else if (extras && n == 10) begin
        creq[k] = 1'b1;
        idle(k, 1);
        creq[k] = 1'b0;
      end else begin
        idle(k, 1);
      end
      n++;
    end
    model_clear(k);
    run_mode[k] = 1'b1;
    chk(k, "clear length in cycles", 32'(n), 32'(depth_of(k) + (extras ? 3 : 0)));
    chk(k, "clear_done after clear", 32'(cdone[k]), 32'd1);
    chk(k, "clear_busy after clear", 32'(cbusy[k]), 32'd0);
  endtask

  // ---------------------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------------------
  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int k = 0; k < NDut; k++) begin
      rst_n[k]     = 1'b0;
      cs[k]        = 1'b0;
      rd[k]        = 1'b0;
      wr[k]        = 1'b0;
      addr[k]      = '0;
      wdata[k]     = '0;
      be[k]        = '0;
      clken[k]     = 1'b1;
      creq[k]      = 1'b0;
      ecnt[k]      = 0;
      last_cnt[k]  = 0;
      last_data[k] = '0;
      last_rdv[k]  = 1'b0;
    end
    run_mode[0] = 1'b0;
    run_mode[1] = 1'b1;
    repeat (3) tick();

    for (int k = 0; k < NDut; k++) begin
      chk(k, "reset readdatavalid", 32'(rdv[k]), 32'd0);
      chk(k, "reset readdata", rdata[k], 32'h0);
      chk(k, "reset clear_done", 32'(cdone[k]), 32'd0);
      chk(k, "reset waitrequest", 32'(wreq[k]), (k == 0) ? 32'd1 : 32'd0);
      chk(k, "reset clear_busy", 32'(cbusy[k]), (k == 0) ? 32'd1 : 32'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    run_clear(0, 1'b0, 1'b0);
    run_clear(1, 1'b1, 1'b0);

    // dut0: cleared words, masked write, read-after-write, read+write collision.
    rd1(0, 0);    idle(0, 1);
    rd1(0, 511);  idle(0, 1);
    rd1(0, 1023); idle(0, 1);
    wr1(0, 5, 32'hDEAD_BEEF, 4'b0101); idle(0, 1);
    rd1(0, 5);    idle(0, 1);
    wr1(0, 7, 32'h1234_5678, 4'hF);
    rd1(0, 7);    idle(0, 1);
    cyc(0, 1, 1, 1, 9, 32'hCAFE_F00D, 4'hF, 1);
    rd1(0, 9);    idle(0, 3);

    // dut1: back-to-back latency-2 reads, then a read stretched by 3 frozen cycles.
    wr1(1, 1, 32'h11, 4'hF);
    wr1(1, 2, 32'h22, 4'hF);
    wr1(1, 3, 32'h33, 4'hF);
    rd1(1, 1);
    rd1(1, 2);
    rd1(1, 3);
    idle(1, 4);
    rd1(1, 2);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    idle(1, 4);

    // Random traffic on both instances at once.
    for (int i = 0; i < 400; i++) begin
      random_drive(0);
      random_drive(1);
      tick();
    end
    idle(0, 1);
    idle(1, 4);

    // dut1: clear_req with dropped write, freeze and ignored re-request; then full readback.
    run_clear(1, 1'b1, 1'b1);
    for (int a = 0; a < 16; a++) rd1(1, a);
    idle(1, 4);

    // dut0: asynchronous reset in the middle of a requested clear.
    run_mode[0] = 1'b0;
    creq[0] = 1'b1;
    idle(0, 1);
    creq[0] = 1'b0;
    idle(0, 300);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk(0, "async reset readdatavalid", 32'(rdv[0]), 32'd0);
    chk(0, "async reset readdata", rdata[0], 32'h0);
    chk(0, "async reset clear_done", 32'(cdone[0]), 32'd0);
    chk(0, "async reset waitrequest", 32'(wreq[0]), 32'd1);
    chk(0, "async reset clear_busy", 32'(cbusy[0]), 32'd1);
    tick();
    tick();
    rst_n[0] = 1'b1;
    run_clear(0, 1'b0, 1'b0);
    rd1(0, 0);
    rd1(0, 100);
    rd1(0, 1023);
    idle(0, 4);

    chk(0, "results left in scoreboard", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
